reg_file_wm: RTL and testbench
==============================

Name: reg_file_wm

Overview:
Parametrised successor to the UART-system configuration register file. It has independent write and read ports, each usable in the same cycle, with bit-level write masking. Other features: a per-address read-only mask, a non-power-of-two depth with out-of-range error reporting, a selectable read latency of 1 or 2 cycles, and a flattened bus exposing the first NUM_CFG registers to the UART/ALU control logic.

Parameters:
WIDTH, 8, data bits per register
DEPTH, 16, number of registers (need not be a power of two, 2..2**ADDR_BITS)
ADDR_BITS, 4, address width
NUM_CFG, 4, number of low registers exposed on CFG_REGS (1..DEPTH)
RD_LATENCY, 1, read latency in cycles (legal values 1 or 2)
RO_MASK, 0, DEPTH-bit vector; bit i = 1 makes register i read-only to the write port
RST_VAL, 0, DEPTH*WIDTH packed reset image; register i = RST_VAL[i*WIDTH +: WIDTH]

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
WrEn  input  1  write request
WrAddr  input  ADDR_BITS  write address
WrData  input  WIDTH  write data
WrMask  input  WIDTH  bit-enable: 1 = bit written, 0 = bit retained
RdEn  input  1  read request
RdAddr  input  ADDR_BITS  read address
RdData  output  WIDTH  read data, valid only while RdData_Valid = 1, else 0
RdData_Valid  output  1  one-cycle pulse per accepted read
RdErr  output  1  qualifies RdData_Valid: read address was out of range
WrErr  output  1  one-cycle pulse: previous-cycle write was rejected
CFG_REGS  output  NUM_CFG*WIDTH  registers 0..NUM_CFG-1 packed, reg 0 in LSBs, registered (no comb path from inputs)

Behaviour:
- Reset: the state below applies while RST = 1 at a clock edge.
  - Register i loads RST_VAL slice i.
  - RdData = 0, RdData_Valid = 0, RdErr = 0, WrErr = 0.
  - The read pipeline is flushed; in-flight reads are dropped and produce no Valid.
  - RST overrides WrEn and RdEn in the same cycle.
- Write: a write is accepted when WrEn = 1, WrAddr < DEPTH and RO_MASK[WrAddr] = 0.
  - Update: RF[a] <= (RF[a] & ~WrMask) | (WrData & WrMask).
  - WrMask = 0 is an accepted no-op with no error.
- Write rejection: WrEn = 1 with an out-of-range or read-only address.
  - No register changes.
  - WrErr = 1 on the next cycle only.
- Read: RdEn = 1 issues a read; back-to-back reads are allowed, one per cycle with no bubbles.
  - RD_LATENCY = 1: RdData/RdData_Valid are registered on the edge that samples RdEn, visible the following cycle.
  - RD_LATENCY = 2: one extra output register stage is added.
  - Each issued read yields exactly one Valid pulse; order is preserved.
- Out-of-range read (RdAddr >= DEPTH): RdData_Valid = 1, RdErr = 1, RdData = 0.
- Read/write collision: same cycle, same address, write accepted.
  - The read is write-first: it returns the merged new value (bypass), not the stale value.
  - If the write was rejected, the read returns the unchanged stored value.
- RD_LATENCY = 2 timing: the data value is captured in the first stage.
  - A write landing in the second-stage cycle does not alter the in-flight data.
- Read-only registers: still readable and exposed on CFG_REGS.
- CFG_REGS: reflects register contents after every edge, i.e. one cycle after an accepted write.
- No FSM: the state is the array, the read pipeline valid/err/data stages and the WrErr flop.
- Elaboration check: RD_LATENCY outside {1, 2}, NUM_CFG > DEPTH or DEPTH > 2**ADDR_BITS is an error.

Decomposition:
- Package reg_file_pkg holds:
  - localparams for the legal RD_LATENCY values;
  - a function that extracts the slice for register i from a packed reset image;
  - the default UART reset image: reg0 = 8'h01 parity/enable, reg1 = 8'h20 prescale 32, others 0.
- Sub-module reg_file_rd_pipe: parametrised on WIDTH and RD_LATENCY.
  - Carries {valid, err, data} through 1 or 2 register stages.
  - Has a synchronous flush on RST.
- The top level holds the array, write logic, bypass mux and CFG_REGS packing.

Test Plan:
- Reset, then read all addresses with defaults, RST_VAL = UART image -> reads return 0x01, 0x20, then 0x00; RdErr = 0; Valid one cycle after RdEn (latency 1) and two cycles after (latency 2).
- Write addr 3 data 0xAB mask 0xFF, then addr 3 data 0x00 mask 0x0F -> read addr 3 = 0xA0; CFG_REGS[31:24] = 0xA0 one cycle after the second write.
- RO_MASK bit 1 set, write addr 1 = 0x55 -> WrErr pulses once; reg 1 stays 0x20. DEPTH = 12, write addr 13 -> WrErr = 1. Read addr 13 -> Valid = 1, RdErr = 1, RdData = 0.
- Same-cycle write addr 5 = 0x3C with read addr 5 -> RdData = 0x3C. Repeat with addr 1 read-only -> RdData = 0x20 and WrErr = 1.
- Four back-to-back reads of addrs 0, 1, 2, 3 with RD_LATENCY = 2 -> four consecutive Valid pulses in order. Assert RST during the third -> no further Valid; all registers back to RST_VAL.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the configuration register file: legal read latencies,
// reset-image slicing helper and the default UART configuration image.
package reg_file_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Upper bounds accepted by rst_slice; the top level checks its parameters against them.
  localparam int RST_IMG_MAX_BITS = 2048;
  localparam int SLICE_MAX_BITS   = 64;

  localparam int UART_CFG_DEPTH = 16;
  localparam int UART_CFG_WIDTH = 8;

  // reg0 = parity/enable, reg1 = prescale 32, all others cleared
  localparam logic [UART_CFG_DEPTH*UART_CFG_WIDTH-1:0] UART_RST_IMAGE =
    {{(UART_CFG_DEPTH-2)*UART_CFG_WIDTH{1'b0}}, 8'h20, 8'h01};

  function automatic logic [SLICE_MAX_BITS-1:0] rst_slice(
    input logic [RST_IMG_MAX_BITS-1:0] img,
    input int                          width,
    input int                          idx
  );
    logic [RST_IMG_MAX_BITS-1:0] shifted;
    logic [SLICE_MAX_BITS-1:0]   keep;
    shifted = img >> (idx * width);
    keep    = (SLICE_MAX_BITS'(1) << width) - SLICE_MAX_BITS'(1);
    return shifted[SLICE_MAX_BITS-1:0] & keep;
  endfunction

endpackage

// File: rtl/reg_file_rd_pipe.sv
// Read response pipeline carrying {valid, err, data}; latency RD_LATENCY (1 or 2).
// No backpressure: one response per request, RST flushes every stage.
module reg_file_rd_pipe #(
  parameter int WIDTH      = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_vld,
  input  logic             req_err,
  input  logic [WIDTH-1:0] req_dat,
  output logic             rsp_vld,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_dat
);

  logic             s1_vld;
  logic             s1_err;
  logic [WIDTH-1:0] s1_dat;

  // Data is forced to zero whenever no response is carried.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld <= 1'b0;
      s1_err <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= req_vld;
      s1_err <= req_vld && req_err;
      s1_dat <= req_vld ? req_dat : '0;
    end
  end

  if (RD_LATENCY == 2) begin : g_two_stage
    logic             s2_vld;
    logic             s2_err;
    logic [WIDTH-1:0] s2_dat;

    always_ff @(posedge CLK) begin
      if (RST) begin
        s2_vld <= 1'b0;
        s2_err <= 1'b0;
        s2_dat <= '0;
      end else begin
        s2_vld <= s1_vld;
        s2_err <= s1_err;
        s2_dat <= s1_dat;
      end
    end

    assign rsp_vld = s2_vld;
    assign rsp_err = s2_err;
    assign rsp_dat = s2_dat;
  end else begin : g_one_stage
    assign rsp_vld = s1_vld;
    assign rsp_err = s1_err;
    assign rsp_dat = s1_dat;
  end

endmodule

// File: rtl/reg_file_wm.sv
// Masked-write configuration register file with write-first read bypass; read latency RD_LATENCY.
// No backpressure: one write and one read accepted every cycle, bad accesses flagged via WrErr/RdErr.
module reg_file_wm
  import reg_file_pkg::*;
#(
  parameter int                     WIDTH      = 8,
  parameter int                     DEPTH      = 16,
  parameter int                     ADDR_BITS  = 4,
  parameter int                     NUM_CFG    = 4,
  parameter int                     RD_LATENCY = 1,
  parameter logic [DEPTH-1:0]       RO_MASK    = '0,
  parameter logic [DEPTH*WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic [ADDR_BITS-1:0]     WrAddr,
  input  logic [WIDTH-1:0]         WrData,
  input  logic [WIDTH-1:0]         WrMask,
  input  logic                     RdEn,
  input  logic [ADDR_BITS-1:0]     RdAddr,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_Valid,
  output logic                     RdErr,
  output logic                     WrErr,
  output logic [NUM_CFG*WIDTH-1:0] CFG_REGS
);

  localparam int ADDR_SPAN = 2 ** ADDR_BITS;

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("reg_file_wm: RD_LATENCY must be 1 or 2");
  end
  if (NUM_CFG < 1 || NUM_CFG > DEPTH) begin : g_bad_num_cfg
    $error("reg_file_wm: NUM_CFG must be within 1..DEPTH");
  end
  if (DEPTH < 2 || DEPTH > ADDR_SPAN) begin : g_bad_depth
    $error("reg_file_wm: DEPTH must be within 2..2**ADDR_BITS");
  end
  if (DEPTH * WIDTH > RST_IMG_MAX_BITS || WIDTH > SLICE_MAX_BITS) begin : g_bad_image
    $error("reg_file_wm: reset image exceeds package limits");
  end

  // Read-only mask padded to the full address span; unused addresses are out of range anyway.
  localparam logic [ADDR_SPAN-1:0] RO_PAD = ADDR_SPAN'(RO_MASK);

  logic [WIDTH-1:0] rf [DEPTH];
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] rd_cur;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_dat;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_acc;
  logic             wr_rej;
  logic             rd_hit;
  logic             wr_err_q;

  assign wr_in_range = int'(WrAddr) < DEPTH;
  assign rd_in_range = int'(RdAddr) < DEPTH;
  assign wr_acc      = WrEn && wr_in_range && !RO_PAD[WrAddr];
  assign wr_rej      = WrEn && !wr_acc;
  assign rd_hit      = wr_acc && (WrAddr == RdAddr);

  // Explicit decode keeps out-of-range addresses from indexing past the array.
  always_comb begin
    wr_cur = '0;
    rd_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(WrAddr) == i) wr_cur = rf[i];
      if (int'(RdAddr) == i) rd_cur = rf[i];
    end
  end

  assign wr_merged = (wr_cur & ~WrMask) | (WrData & WrMask);

  // Write-first: a same-cycle accepted write to the read address is forwarded.
  always_comb begin
    rd_dat = '0;
    if (rd_in_range) begin
      rd_dat = rd_hit ? wr_merged : rd_cur;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= WIDTH'(rst_slice(RST_IMG_MAX_BITS'(RST_VAL), WIDTH, i));
      end
    end else if (wr_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(WrAddr) == i) rf[i] <= wr_merged;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_rej;
    end
  end

  assign WrErr = wr_err_q;

  reg_file_rd_pipe #(
    .WIDTH      (WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .req_vld (RdEn),
    .req_err (!rd_in_range),
    .req_dat (rd_dat),
    .rsp_vld (RdData_Valid),
    .rsp_err (RdErr),
    .rsp_dat (RdData)
  );

  // Straight from the array flops, so no combinational path from any input.
  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign CFG_REGS[g*WIDTH +: WIDTH] = rf[g];
  end

endmodule

// File: tb/tb_reg_file_wm.sv
// Scoreboard bench: identical stimulus drives a latency-1 and a latency-2 instance,
// expected read responses are queued at issue and popped by a negedge monitor.
module tb_reg_file_wm;
  import reg_file_pkg::*;

  localparam int W  = 8;
  localparam int D  = 12;
  localparam int AB = 4;
  localparam int NC = 4;
  localparam logic [D-1:0]   RO = 12'b0000_0000_0010;
  localparam logic [D*W-1:0] RV = UART_RST_IMAGE[D*W-1:0];

  typedef struct {
    int         due;
    logic [W-1:0] dat;
    logic       err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic WrEn = 1'b0;
  logic RdEn = 1'b0;
  logic [AB-1:0] WrAddr = '0;
  logic [AB-1:0] RdAddr = '0;
  logic [W-1:0]  WrData = '0;
  logic [W-1:0]  WrMask = '0;

  logic [W-1:0]    rd_dat1, rd_dat2;
  logic            vld1, vld2, err1, err2, wrerr1, wrerr2;
  logic [NC*W-1:0] cfg1, cfg2;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [W-1:0] mdl [D];
  logic       exp_wrerr = 1'b0;
  int         cyc = 0;
  bit         armed = 1'b0;
  int         tests = 0;
  int         fails = 0;

  always #5 CLK = ~CLK;

  reg_file_wm #(.WIDTH(W), .DEPTH(D), .ADDR_BITS(AB), .NUM_CFG(NC), .RD_LATENCY(1),
                .RO_MASK(RO), .RST_VAL(RV)) u_lat1 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrMask(WrMask),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rd_dat1), .RdData_Valid(vld1), .RdErr(err1),
    .WrErr(wrerr1), .CFG_REGS(cfg1));

  reg_file_wm #(.WIDTH(W), .DEPTH(D), .ADDR_BITS(AB), .NUM_CFG(NC), .RD_LATENCY(2),
                .RO_MASK(RO), .RST_VAL(RV)) u_lat2 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrMask(WrMask),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rd_dat2), .RdData_Valid(vld2), .RdErr(err2),
    .WrErr(wrerr2), .CFG_REGS(cfg2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [NC*W-1:0] model_cfg();
    logic [NC*W-1:0] r;
    for (int i = 0; i < NC; i++) r[i*W +: W] = mdl[i];
    return r;
  endfunction

  // One clock of stimulus; the reference model advances on the same edge.
  task automatic step(input bit rst, input bit we, input int wa, input int wd, input int wm,
                      input bit re, input int ra);
    bit           wok;
    exp_t         e;
    logic [W-1:0] mask, data;
    RST = rst; WrEn = we; WrAddr = AB'(wa); WrData = W'(wd); WrMask = W'(wm);
    RdEn = re; RdAddr = AB'(ra);
    @(posedge CLK);
    cyc++;
    mask = W'(wm);
    data = W'(wd);
    if (rst) begin
      for (int i = 0; i < D; i++) mdl[i] = RV[i*W +: W];
      q1.delete();
      q2.delete();
      exp_wrerr = 1'b0;
      armed = 1'b1;
    end else begin
      wok = we && (wa < D) && (RO[wa % D] == 1'b0);
      if (re) begin
        e.err = (ra >= D);
        if (ra >= D)               e.dat = '0;
        else if (wok && wa == ra)  e.dat = (mdl[ra] & ~mask) | (data & mask);
        else                       e.dat = mdl[ra];
        e.due = cyc;
        q1.push_back(e);
        e.due = cyc + 1;
        q2.push_back(e);
      end
      if (wok) mdl[wa] = (mdl[wa] & ~mask) | (data & mask);
      exp_wrerr = we && !wok;
    end
    #1;
  endtask

  task automatic port(input int lane, input logic v, input logic e, input logic [W-1:0] d);
    exp_t ex;
    int   n;
    n = (lane == 1) ? q1.size() : q2.size();
    if (n > 0) ex = (lane == 1) ? q1[0] : q2[0];
    if (v) begin
      if (n == 0) begin
        chk($sformatf("rd%0d_spurious_valid", lane), 64'(v), 64'd0);
      end else begin
        if (lane == 1) void'(q1.pop_front()); else void'(q2.pop_front());
        chk($sformatf("rd%0d_cycle", lane), 64'(cyc), 64'(ex.due));
        chk($sformatf("rd%0d_err", lane), 64'(e), 64'(ex.err));
        chk($sformatf("rd%0d_dat", lane), 64'(d), 64'(ex.dat));
      end
    end else begin
      chk($sformatf("rd%0d_idle_dat", lane), 64'(d), 64'd0);
      if (n > 0 && ex.due <= cyc) begin
        chk($sformatf("rd%0d_missing_valid", lane), 64'(v), 64'd1);
        if (lane == 1) void'(q1.pop_front()); else void'(q2.pop_front());
      end
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      chk("wrerr1", 64'(wrerr1), 64'(exp_wrerr));
      chk("wrerr2", 64'(wrerr2), 64'(exp_wrerr));
      chk("cfg1", 64'(cfg1), 64'(model_cfg()));
      chk("cfg2", 64'(cfg2), 64'(model_cfg()));
      port(1, vld1, err1, rd_dat1);
      port(2, vld2, err2, rd_dat2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int wm;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    for (int a = 0; a < D; a++) step(0, 0, 0, 0, 0, 1, a);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 'hAB, 'hFF, 0, 0);
    step(0, 1, 3, 'h00, 'h0F, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 1, 1, 'h55, 'hFF, 0, 0);
    step(0, 1, 13, 'h11, 'hFF, 0, 0);
    step(0, 0, 0, 0, 0, 1, 13);
    step(0, 1, 5, 'h3C, 'hFF, 1, 5);
    step(0, 1, 1, 'h77, 'hFF, 1, 1);
    step(0, 1, 2, 'h5A, 'h00, 1, 2);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 1, 4, 'hEE, 'hFF, 1, 2);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < NC; a++) step(0, 0, 0, 0, 0, 1, a);
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(2))
        0:       wm = 'hFF;
        1:       wm = 0;
        default: wm = int'($urandom_range(255));
      endcase
      step(($urandom_range(63) == 0), ($urandom_range(1) == 1), int'($urandom_range(15)),
           int'($urandom_range(255)), wm, ($urandom_range(3) != 0), int'($urandom_range(15)));
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    chk("rd1_drained", 64'(q1.size()), 64'd0);
    chk("rd2_drained", 64'(q2.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
